window_ctrl: RTL and testbench

- Register-window controller for the SPARC V8 integer unit.
- Owns CWP and the WIM register.
- Sequences SAVE / RESTORE / RETT / WRPSR-CWP requests from decode, checks the target window against WIM, and either commits the new CWP or raises a window overflow/underflow/illegal trap to the trap unit with a valid/ack handshake.
- Sits between decode and the register file window-select logic.

---
 rtl/window_pkg.sv | 26 ++
 rtl/window_mod_step.sv | 26 ++
 rtl/window_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_window_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// window_pkg: shared types and constants for the SPARC V8 register-window
// controller.
//   - op_e    : request opcodes as presented on req_op
//   - state_e : controller FSM states
//   - TT_*    : trap types raised to the trap unit
package window_pkg;

  typedef enum logic [1:0] {
    OP_SAVE    = 2'b00,
    OP_RESTORE = 2'b01,
    OP_RETT    = 2'b10,
    OP_WRCWP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_TRAP   = 2'd3
  } state_e;

  localparam logic [7:0] TT_WIN_OVF = 8'h05;
  localparam logic [7:0] TT_WIN_UNF = 8'h06;
  localparam logic [7:0] TT_ILLEGAL = 8'h02;

endpackage

// File: rtl/window_mod_step.sv
// window_mod_step: combinational modulo-NWINDOWS step of a window pointer.
//   cwp_i : current window pointer (always < NWINDOWS)
//   dec_i : 1 = step down (0 wraps to NWINDOWS-1), 0 = step up
//           (NWINDOWS-1 wraps to 0)
//   cwp_o : stepped window pointer
module window_mod_step #(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 5
) (
  input  logic [CWP_W-1:0] cwp_i,
  input  logic             dec_i,
  output logic [CWP_W-1:0] cwp_o
);

  localparam logic [CWP_W-1:0] LAST = CWP_W'(NWINDOWS - 1);

  always_comb begin
    cwp_o = '0;
    if (dec_i) begin
      cwp_o = (cwp_i == '0) ? LAST : (cwp_i - CWP_W'(1));
    end else begin
      cwp_o = (cwp_i == LAST) ? '0 : (cwp_i + CWP_W'(1));
    end
  end

endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: register-window controller for the SPARC V8 integer unit.
// Owns CWP and WIM. Sequences SAVE / RESTORE / RETT / WRCWP requests from
// decode, checks the target window against WIM and either commits the new
// CWP or raises a window overflow / underflow / illegal trap.
//
// Ports:
//   Clk, Clr           : clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready: request handshake; ready only while idle
//   req_op, req_cwp    : opcode (window_pkg::op_e) and WRCWP target
//   wim_we, wim_wdata  : WIM write; bits at and above NWINDOWS read as 0
//   trap_valid/trap_tt : trap request to the trap unit, held until trap_ack
//   trap_ack           : trap unit accepts the trap
//   done, done_trap    : one-cycle completion pulse, done_trap = trapped
//   cwp, wim           : current window pointer and window invalid mask
//   ovf_count, unf_count (WIN_STATS_EN only): saturating counts of acked
//                        overflow / underflow traps
//
// Build option: define WIN_STATS_EN to add the trap statistics counters.
module window_ctrl
  import window_pkg::*;
#(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 5
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CWP_W-1:0] req_cwp,
  input  logic             wim_we,
  input  logic [31:0]      wim_wdata,
  output logic             trap_valid,
  output logic [7:0]       trap_tt,
  input  logic             trap_ack,
  output logic             done,
  output logic             done_trap,
`ifdef WIN_STATS_EN
  output logic [15:0]      ovf_count,
  output logic [15:0]      unf_count,
`endif
  output logic [CWP_W-1:0] cwp,
  output logic [31:0]      wim
);

  localparam logic [31:0] WIM_MASK =
    (NWINDOWS >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << NWINDOWS) - 64'd1);

  state_e           state_q;
  op_e              op_q;
  logic [CWP_W-1:0] op_cwp_q;
  logic [CWP_W-1:0] tgt_q;
  logic [CWP_W-1:0] cwp_q;
  logic [31:0]      wim_q;
  logic             trap_valid_q;
  logic [7:0]       trap_tt_q;
  logic             done_q;
  logic             done_trap_q;

  logic [CWP_W-1:0] step_tgt;
  logic [CWP_W-1:0] trap_cwp;
  logic [CWP_W-1:0] eval_tgt_d;
  logic             eval_trap_d;
  logic [7:0]       eval_tt_d;

  // Neighbour window for SAVE (down) or RESTORE/RETT (up).
  window_mod_step #(
    .NWINDOWS (NWINDOWS),
    .CWP_W    (CWP_W)
  ) u_step_tgt (
    .cwp_i (cwp_q),
    .dec_i (op_q == OP_SAVE),
    .cwp_o (step_tgt)
  );

  // Trap entry always moves one window down, without a WIM check.
  window_mod_step #(
    .NWINDOWS (NWINDOWS),
    .CWP_W    (CWP_W)
  ) u_step_trap (
    .cwp_i (cwp_q),
    .dec_i (1'b1),
    .cwp_o (trap_cwp)
  );

  // Evaluation uses the registered WIM, so a WIM write landing on the EVAL
  // edge only affects later requests.
  always_comb begin
    eval_tgt_d  = step_tgt;
    eval_trap_d = 1'b0;
    eval_tt_d   = '0;
    unique case (op_q)
      OP_SAVE: begin
        eval_trap_d = wim_q[step_tgt];
        eval_tt_d   = TT_WIN_OVF;
      end
      OP_RESTORE, OP_RETT: begin
        eval_trap_d = wim_q[step_tgt];
        eval_tt_d   = TT_WIN_UNF;
      end
      OP_WRCWP: begin
        eval_tgt_d  = op_cwp_q;
        eval_trap_d = ({1'b0, op_cwp_q} >= (CWP_W + 1)'(NWINDOWS));
        eval_tt_d   = TT_ILLEGAL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_SAVE;
      op_cwp_q     <= '0;
      tgt_q        <= '0;
      cwp_q        <= '0;
      wim_q        <= '0;
      trap_valid_q <= 1'b0;
      trap_tt_q    <= '0;
      done_q       <= 1'b0;
      done_trap_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      done_trap_q <= 1'b0;

      if (wim_we) begin
        wim_q <= wim_wdata & WIM_MASK;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= op_e'(req_op);
            op_cwp_q <= req_cwp;
            state_q  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (eval_trap_d) begin
            trap_valid_q <= 1'b1;
            trap_tt_q    <= eval_tt_d;
            state_q      <= ST_TRAP;
          end else begin
            tgt_q   <= eval_tgt_d;
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          cwp_q   <= tgt_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_TRAP: begin
          if (trap_ack) begin
            cwp_q        <= trap_cwp;
            trap_valid_q <= 1'b0;
            done_q       <= 1'b1;
            done_trap_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WIN_STATS_EN
  logic [15:0] ovf_count_q;
  logic [15:0] unf_count_q;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ovf_count_q <= '0;
      unf_count_q <= '0;
    end else if (state_q == ST_TRAP && trap_ack) begin
      if (trap_tt_q == TT_WIN_OVF && ovf_count_q != '1) begin
        ovf_count_q <= ovf_count_q + 16'd1;
      end
      if (trap_tt_q == TT_WIN_UNF && unf_count_q != '1) begin
        unf_count_q <= unf_count_q + 16'd1;
      end
    end
  end

  assign ovf_count = ovf_count_q;
  assign unf_count = unf_count_q;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign trap_valid = trap_valid_q;
  assign trap_tt    = trap_tt_q;
  assign done       = done_q;
  assign done_trap  = done_trap_q;
  assign cwp        = cwp_q;
  assign wim        = wim_q;

endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: self-checking bench for window_ctrl with NWINDOWS=4.
// Directed steps followed by randomized requests, checked against a
// window-arithmetic reference model (cwp/wim as plain integers).
module tb_window_ctrl;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_cwp = '0;
  logic        wim_we = 1'b0;
  logic [31:0] wim_wdata = '0;
  logic        trap_valid;
  logic [7:0]  trap_tt;
  logic        trap_ack = 1'b0;
  logic        done;
  logic        done_trap;
  logic [4:0]  cwp;
  logic [31:0] wim;
`ifdef WIN_STATS_EN
  logic [15:0] ovf_count;
  logic [15:0] unf_count;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_cwp = 0;
  int unsigned m_wim = 0;
  int m_ovf = 0;
  int m_unf = 0;

  window_ctrl #(.NWINDOWS(N), .CWP_W(5)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_cwp    (req_cwp),
    .wim_we     (wim_we),
    .wim_wdata  (wim_wdata),
    .trap_valid (trap_valid),
    .trap_tt    (trap_tt),
    .trap_ack   (trap_ack),
    .done       (done),
    .done_trap  (done_trap),
`ifdef WIN_STATS_EN
    .ovf_count  (ovf_count),
    .unf_count  (unf_count),
`endif
    .cwp        (cwp),
    .wim        (wim)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wrwim(input logic [31:0] data);
    wim_we    = 1'b1;
    wim_wdata = data;
    tick();
    wim_we = 1'b0;
    m_wim  = data & ((32'd1 << N) - 1);
    check("wim_write", wim, m_wim);
  endtask

  // One full request. ew_en drives a WIM write onto the EVAL edge.
  task automatic do_req(input int op, input int rcwp, input int ack_dly,
                        input bit ew_en, input logic [31:0] ew_data);
    int  tgt;
    bit  exp_trap;
    int  exp_tt;
    int  old_cwp;
    old_cwp  = m_cwp;
    exp_trap = 1'b0;
    exp_tt   = 0;
    tgt      = 0;
    case (op)
      0: begin
        tgt = (m_cwp + N - 1) % N;
        exp_trap = m_wim[tgt];
        exp_tt = 5;
      end
      1, 2: begin
        tgt = (m_cwp + 1) % N;
        exp_trap = m_wim[tgt];
        exp_tt = 6;
      end
      default: begin
        tgt = rcwp;
        exp_trap = (rcwp >= N);
        exp_tt = 2;
      end
    endcase

    check("ready_idle", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_op    = op[1:0];
    req_cwp   = rcwp[4:0];
    tick();
    req_valid = 1'b0;
    check("ready_busy", {31'd0, req_ready}, 0);
    if (ew_en) begin
      wim_we    = 1'b1;
      wim_wdata = ew_data;
    end
    tick();
    wim_we = 1'b0;
    if (ew_en) m_wim = ew_data & ((32'd1 << N) - 1);

    if (!exp_trap) begin
      check("commit_cwp_hold", {27'd0, cwp}, old_cwp);
      check("commit_done_early", {31'd0, done}, 0);
      check("commit_no_trap", {31'd0, trap_valid}, 0);
      tick();
      m_cwp = tgt;
      check("commit_cwp", {27'd0, cwp}, m_cwp);
      check("commit_done", {30'd0, done, done_trap}, 2);
    end else begin
      check("trap_valid", {31'd0, trap_valid}, 1);
      check("trap_tt", {24'd0, trap_tt}, exp_tt);
      check("trap_cwp_hold", {27'd0, cwp}, old_cwp);
      for (int i = 0; i < ack_dly; i++) begin
        // Requests presented while busy must be ignored.
        req_valid = 1'b1;
        req_op    = 2'($urandom_range(0, 3));
        tick();
        check("trap_wait", {22'd0, trap_valid, req_ready, done, trap_tt}, {3'b100, 8'(exp_tt)});
        check("trap_wait_cwp", {27'd0, cwp}, old_cwp);
      end
      req_valid = 1'b0;
      trap_ack  = 1'b1;
      tick();
      trap_ack = 1'b0;
      m_cwp = (old_cwp + N - 1) % N;
      if (exp_tt == 5 && m_ovf < 65535) m_ovf++;
      if (exp_tt == 6 && m_unf < 65535) m_unf++;
      check("ack_trap_valid", {31'd0, trap_valid}, 0);
      check("ack_cwp", {27'd0, cwp}, m_cwp);
      check("ack_done", {30'd0, done, done_trap}, 3);
    end
    tick();
    check("done_pulse_end", {31'd0, done}, 0);
    check("wim_track", wim, m_wim);
  endtask

  initial begin
    // Reset
    Clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Clr = 1'b1;
    check("rst_cwp", {27'd0, cwp}, 0);
    check("rst_wim", wim, 0);
    check("rst_trap", {23'd0, trap_valid, trap_tt}, 0);
    check("rst_done", {30'd0, done, done_trap}, 0);
    check("rst_ready", {31'd0, req_ready}, 1);
    tick();

    // SAVE from 0 wraps to 3, not masked
    wrwim(32'h1);
    do_req(0, 0, 0, 1'b0, '0);
    check("save_wrap_cwp3", {27'd0, cwp}, 3);

    // SAVE into invalid window 0 -> overflow, ack after 3 cycles
    do_req(3, 1, 0, 1'b0, '0);
    check("wrcwp_1", {27'd0, cwp}, 1);
    do_req(0, 0, 3, 1'b0, '0);
    check("ovf_ack_cwp0", {27'd0, cwp}, 0);

    // RESTORE from 3 wraps to 0 -> underflow, ack moves to 2
    do_req(3, 3, 0, 1'b0, '0);
    do_req(1, 0, 2, 1'b0, '0);
    check("unf_ack_cwp2", {27'd0, cwp}, 2);

    // WRCWP illegal and legal
    do_req(3, 5, 1, 1'b0, '0);
    check("illegal_ack_cwp1", {27'd0, cwp}, 1);
    do_req(3, 2, 0, 1'b0, '0);
    check("wrcwp_2", {27'd0, cwp}, 2);

    // RETT up into masked window
    wrwim(32'h8);
    do_req(2, 0, 0, 1'b0, '0);
    check("rett_trap_cwp1", {27'd0, cwp}, 1);

    // WIM upper bits dropped
    wrwim(32'hFFFF_FFFF);
    check("wim_masked", wim, 32'h0000_000F);

    // WIM write on EVAL edge is not seen by that request
    wrwim(32'h0);
    do_req(0, 0, 0, 1'b1, 32'hF);
    check("eval_wim_nosee_cwp0", {27'd0, cwp}, 0);
    do_req(1, 0, 0, 1'b1, 32'h0);
    check("eval_wim_nosee_trap_cwp3", {27'd0, cwp}, 3);

    // Async reset in the middle of a trap
    wrwim(32'h1);
    do_req(3, 1, 0, 1'b0, '0);
    req_valid = 1'b1;
    req_op    = 2'b00;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_trap", {31'd0, trap_valid}, 1);
    #2;
    Clr = 1'b0;
    #1;
    check("midtrap_rst_trap", {31'd0, trap_valid}, 0);
    check("midtrap_rst_cwp", {27'd0, cwp}, 0);
    check("midtrap_rst_wim", wim, 0);
    check("midtrap_rst_ready", {31'd0, req_ready}, 1);
    m_cwp = 0;
    m_wim = 0;
    m_ovf = 0;
    m_unf = 0;
`ifdef WIN_STATS_EN
    check("rst_ovf_count", {16'd0, ovf_count}, 0);
`endif
    @(posedge Clk);
    #1;
    Clr = 1'b1;
    tick();

    // Two acknowledged overflows
    wrwim(32'h1);
    do_req(3, 1, 0, 1'b0, '0);
    do_req(0, 0, 1, 1'b0, '0);
    do_req(3, 1, 0, 1'b0, '0);
    do_req(0, 0, 0, 1'b0, '0);
`ifdef WIN_STATS_EN
    check("ovf_count_2", {16'd0, ovf_count}, 2);
`endif

    // All-zero WIM: no traps, free wrap
    wrwim(32'h0);
    for (int i = 0; i < 6; i++) do_req(0, 0, 0, 1'b0, '0);
    check("free_wrap_cwp", {27'd0, cwp}, 2);

    // Randomized requests
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wrwim($urandom & $urandom);
      end else begin
        do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
               $urandom & $urandom);
      end
    end
`ifdef WIN_STATS_EN
    check("rand_ovf_count", {16'd0, ovf_count}, m_ovf);
    check("rand_unf_count", {16'd0, unf_count}, m_unf);
`endif
    check("final_cwp", {27'd0, cwp}, m_cwp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
